mux_arb_reg: RTL and testbench

- Parametrised successor to the team's fixed 4-input, 32-bit combinational multiplexer.
- Selects one of N valid/ready input channels and registers the winning word into a single-entry output stage with a valid/ready handshake.
- Selection is either explicit (sel port, as in the fixed mux) or round-robin arbitration.
- Sits between multiple producers (e.g. result buses, memory return paths) and one consumer in the datapath.

---
 rtl/mux_arb_reg.sv | 103 ++++++++++
 tb/tb_mux_arb_reg.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-channel valid/ready multiplexer with explicit-select or round-robin choice,
// feeding a single registered output stage that sustains one word per cycle.
module mux_arb_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned MODE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  out_chan_q;
    logic [SELW-1:0]  last_q;

    logic             load_en;
    logic             grant;
    logic             cand_ok;
    logic [N-1:0]     onehot;
    logic [N-1:0]     vshift;
    logic [WIDTH-1:0] cand_word;
    logic [SELW-1:0]  cand;
    int unsigned      cand_i;
    int unsigned      idx;
    logic             found;

    always_comb begin
        load_en   = !out_valid_q || out_ready;
        cand_i    = 0;
        idx       = 0;
        found     = 1'b0;
        vshift    = '0;
        onehot    = '0;
        cand_ok   = 1'b0;
        cand_word = '0;

        if (MODE == 0) begin
            // Out-of-range select falls through to the last channel.
            cand_i = (32'(sel) >= N) ? N - 1 : 32'(sel);
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx    = (32'(last_q) + k) % N;
                vshift = in_valid >> idx;
                if (!found && vshift[0]) begin
                    cand_i = idx;
                    found  = 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < N; i++) begin
            if (cand_i == i) begin
                onehot[i] = 1'b1;
                cand_ok   = in_valid[i];
                cand_word = in_data[i*WIDTH +: WIDTH];
            end
        end
        cand = SELW'(cand_i);

        grant    = !reset && load_en && cand_ok;
        in_ready = '0;
        if (!reset && load_en) begin
            if (MODE == 0) begin
                in_ready = onehot;
            end else if (cand_ok) begin
                in_ready = onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SELW'(N - 1);
        end else if (grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cand_word;
            out_chan_q  <= cand;
            if (MODE == 1) begin
                last_q <= cand;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: explicit-select and round-robin instances checked
// against a cycle-level reference model, plus an out-of-range select instance.
module tb_mux_arb_reg;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic [1:0]   sel3;
    logic         out_ready;

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy3;
    logic [31:0] od0, od1, od3;
    logic        ov0, ov1, ov3;
    logic [1:0]  oc0, oc1, oc3;

    int total = 0;
    int bad   = 0;

    // reference model state: index 0 = explicit select, 1 = round-robin
    bit          mv [2];
    logic [31:0] md [2];
    logic [1:0]  mc [2];
    int          mlast;
    logic [31:0] q1 [$];

    mux_arb_reg #(.WIDTH(32), .N(4), .SELW(2), .MODE(0)) d0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .sel(sel), .out_data(od0), .out_valid(ov0),
        .out_ready(out_ready), .out_chan(oc0));

    mux_arb_reg #(.WIDTH(32), .N(4), .SELW(2), .MODE(1)) d1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .sel(sel), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .out_chan(oc1));

    mux_arb_reg #(.WIDTH(32), .N(3), .SELW(2), .MODE(0)) d3 (
        .clk(clk), .reset(reset), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
        .in_ready(rdy3), .sel(sel3), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .out_chan(oc3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(int i);
        return in_data[i*32 +: 32];
    endfunction

    // first valid channel after the previous round-robin winner, -1 if none
    function automatic int rr_pick();
        for (int k = 1; k <= 4; k++)
            if (in_valid[(mlast + k) % 4]) return (mlast + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy0();
        if (reset || (mv[0] && !out_ready)) return 4'b0000;
        return 4'b0001 << sel;
    endfunction

    function automatic logic [3:0] exp_rdy1();
        int p;
        p = rr_pick();
        if (reset || (mv[1] && !out_ready) || p < 0) return 4'b0000;
        return 4'b0001 << p;
    endfunction

    // advance one clock and update the reference model from pre-edge inputs
    task automatic step();
        logic [3:0]  r0, r1, v;
        logic [31:0] w0, w1;
        logic [1:0]  s;
        int          p;
        bit          rs, ordy;
        r0 = exp_rdy0(); r1 = exp_rdy1(); p = rr_pick();
        s = sel; v = in_valid; rs = reset; ordy = out_ready;
        w0 = word(int'(s));
        w1 = (p >= 0) ? word(p) : 32'h0;
        @(posedge clk);
        if (rs) begin
            for (int m = 0; m < 2; m++) begin mv[m] = 0; md[m] = '0; mc[m] = '0; end
            mlast = 3;
        end else begin
            if ((r0 & v) != 0) begin mv[0] = 1; md[0] = w0; mc[0] = s; end
            else if (ordy) mv[0] = 0;
            if ((r1 & v) != 0) begin
                mv[1] = 1; md[1] = w1; mc[1] = 2'(p); mlast = p; q1.push_back(w1);
            end else if (ordy) mv[1] = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 4'hF; out_ready = 1; sel = 0; sel3 = 0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({rdy0, rdy1, rdy3} !== 11'b0) begin
                bad++; $display("FAIL reset_in_ready got=%b/%b/%b want=0", rdy0, rdy1, rdy3);
            end
            step();
            total++;
            if ({ov0, ov1, ov3, od0, od1, od3} !== '0) begin
                bad++; $display("FAIL reset_out got v=%b%b%b d=%h/%h/%h want zeros", ov0, ov1, ov3, od0, od1, od3);
            end
        end
        reset = 0;
        #1;
        total++;
        if (rdy1 !== 4'b0001) begin bad++; $display("FAIL first_grant rdy1=%b want=0001", rdy1); end
        step();
        total++;
        if ({ov1, oc1, od1} !== {1'b1, 2'd0, word(0)}) begin
            bad++; $display("FAIL first_word got v=%b c=%0d d=%h want v=1 c=0 d=%h", ov1, oc1, od1, word(0));
        end
    endtask

    task automatic test_explicit_sel();
        in_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        in_valid = 4'hF; out_ready = 1; sel = 2;
        #1;
        total++;
        if (rdy0 !== 4'b0100) begin bad++; $display("FAIL sel2_ready got=%b want=0100", rdy0); end
        step();
        total++;
        if ({ov0, oc0, od0} !== {1'b1, 2'd2, 32'hCCCCCCCC}) begin
            bad++; $display("FAIL sel2_out got v=%b c=%0d d=%h want 1/2/cccccccc", ov0, oc0, od0);
        end
        sel = 3;
        #1;
        total++;
        if (rdy0 !== 4'b1000) begin bad++; $display("FAIL sel3_ready got=%b want=1000", rdy0); end
        step();
        total++;
        if ({ov0, oc0, od0} !== {1'b1, 2'd3, 32'hDDDDDDDD}) begin
            bad++; $display("FAIL sel3_out got v=%b c=%0d d=%h want 1/3/dddddddd", ov0, oc0, od0);
        end
        // ready may rise on the selected channel without valid; nothing loads
        in_valid = 4'h0; sel = 1;
        #1;
        total++;
        if ({rdy0, rdy1} !== {4'b0010, 4'b0000}) begin
            bad++; $display("FAIL novalid_ready got=%b/%b want=0010/0000", rdy0, rdy1);
        end
        step();
        total++;
        if ({ov0, od0} !== {1'b0, 32'hDDDDDDDD}) begin
            bad++; $display("FAIL drain_hold got v=%b d=%h want 0/dddddddd", ov0, od0);
        end
    endtask

    task automatic test_sel_oob();
        in_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        in_valid = 4'hF; out_ready = 1; sel3 = 3;
        #1;
        total++;
        if (rdy3 !== 3'b100) begin bad++; $display("FAIL oob_ready got=%b want=100", rdy3); end
        step();
        total++;
        if ({ov3, oc3, od3} !== {1'b1, 2'd2, 32'hCCCCCCCC}) begin
            bad++; $display("FAIL oob_out got v=%b c=%0d d=%h want 1/2/cccccccc", ov3, oc3, od3);
        end
    endtask

    task automatic test_round_robin();
        int          seq2 [4] = '{0, 2, 0, 2};
        int          ch;
        logic [31:0] ew;
        reset = 1; step(); reset = 0;
        in_valid = 4'hF; out_ready = 1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 12; k++) begin
            if (k == 8) in_valid = 4'b0101;
            ch = (k < 8) ? k % 4 : seq2[k-8];
            ew = word(ch);
            #1;
            total++;
            if (rdy1 !== (4'b0001 << ch)) begin bad++; $display("FAIL rr_ready k=%0d got=%b want ch%0d", k, rdy1, ch); end
            step();
            total++;
            if ({ov1, oc1, od1} !== {1'b1, 2'(ch), ew}) begin
                bad++; $display("FAIL rr_out k=%0d got v=%b c=%0d d=%h want 1/%0d/%h", k, ov1, oc1, od1, ch, ew);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w1;
        reset = 1; step(); reset = 0;
        w1 = $urandom;
        in_data = {$urandom, $urandom, w1, 32'hAAAAAAAA};
        in_valid = 4'b0001; out_ready = 1;
        step();
        in_valid = 4'b0010; out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (rdy1 !== 4'b0000) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0000", c, rdy1); end
            step();
            total++;
            if ({ov1, oc1, od1} !== {1'b1, 2'd0, 32'hAAAAAAAA}) begin
                bad++; $display("FAIL stall_hold c=%0d got v=%b c=%0d d=%h want 1/0/aaaaaaaa", c, ov1, oc1, od1);
            end
        end
        out_ready = 1;
        #1;
        total++;
        if (rdy1 !== 4'b0010) begin bad++; $display("FAIL release_ready got=%b want=0010", rdy1); end
        step();
        total++;
        if ({ov1, oc1, od1} !== {1'b1, 2'd1, w1}) begin
            bad++; $display("FAIL release_out got v=%b c=%0d d=%h want 1/1/%h", ov1, oc1, od1, w1);
        end
        in_valid = 4'hF;
        #1;
        total++;
        if (rdy1 !== 4'b0100) begin bad++; $display("FAIL ptr_after_stall got=%b want=0100", rdy1); end
        step();
    endtask

    task automatic test_back_to_back();
        int          words_out = 0;
        logic [31:0] ew;
        q1.delete();
        out_ready = 1;
        for (int c = 0; c < 20; c++) begin
            in_valid = 4'($urandom_range(1, 15));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            total++;
            if (ov1 !== 1'b1) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=1", c, ov1); end
            else begin
                words_out++;
                ew = (q1.size() > 0) ? q1.pop_front() : 32'hx;
                total++;
                if (od1 !== ew) begin bad++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, od1, ew); end
            end
        end
        total++;
        if (words_out != 20 || q1.size() != 0) begin
            bad++; $display("FAIL b2b_count got=%0d left=%0d want=20/0", words_out, q1.size());
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b0001; out_ready = 1;
        step();
        out_ready = 0; in_valid = 4'hF; reset = 1;
        #1;
        total++;
        if ({rdy0, rdy1} !== 8'b0) begin bad++; $display("FAIL midreset_ready got=%b/%b want=0", rdy0, rdy1); end
        step();
        total++;
        if ({ov0, ov1} !== 2'b00) begin bad++; $display("FAIL midreset_drop got=%b%b want=00", ov0, ov1); end
        reset = 0; out_ready = 1;
        #1;
        total++;
        if (rdy1 !== 4'b0001) begin bad++; $display("FAIL restart_ready got=%b want=0001", rdy1); end
        step();
        total++;
        if ({ov1, oc1} !== {1'b1, 2'd0}) begin bad++; $display("FAIL restart_out got v=%b c=%0d want 1/0", ov1, oc1); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            reset     = ($urandom % 60) == 0;
            #1;
            total++;
            if ({rdy0, rdy1} !== {exp_rdy0(), exp_rdy1()}) begin
                bad++; $display("FAIL rand_ready c=%0d got=%b/%b want=%b/%b", c, rdy0, rdy1, exp_rdy0(), exp_rdy1());
            end
            step();
            total++;
            if ({ov0, od0, oc0, ov1, od1, oc1} !== {mv[0], md[0], mc[0], mv[1], md[1], mc[1]}) begin
                bad++;
                $display("FAIL rand_out c=%0d got %b/%h/%0d %b/%h/%0d want %b/%h/%0d %b/%h/%0d", c,
                         ov0, od0, oc0, ov1, od1, oc1, mv[0], md[0], mc[0], mv[1], md[1], mc[1]);
            end
        end
        reset = 0;
    endtask

    initial begin
        mlast = 3;
        test_reset();
        test_explicit_sel();
        test_sel_oob();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
